// File: rtl/gen_cmd_ctrl.sv
// Command controller: decodes 16-bit UART words into generator configuration and user-RAM writes.
// Optional macro PHASE_SHADOW_EN stages phase bytes 0-2 and commits all 32 bits on byte 3.
`timescale 1ns/1ps

module gen_cmd_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 7
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [15:0]       rx_data,
  input  logic              rx_done,
  output logic              uart_ack,
  output logic [31:0]       phase_step,
  output logic [1:0]        wave_type,
  output logic              gen_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MEMWR,
    ACK,
    WAIT_REL
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] word_q;

  logic        is_mem;
  logic        is_gen;
  logic        is_wave;
  logic        is_phase;
  logic        is_err;
  logic [1:0]  byte_idx;

  logic        ack_d;
  logic        we_d;
  logic        err_d;
  logic        busy_d;

`ifdef PHASE_SHADOW_EN
  logic [23:0] shadow;
`endif

  assign is_mem   = ~word_q[15];
  assign is_gen   = word_q[15] && (word_q[14:12] == 3'b001);
  assign is_wave  = word_q[15] && (word_q[14:12] == 3'b010);
  assign is_phase = word_q[15] && (word_q[14:12] == 3'b011);
  assign is_err   = word_q[15] && !is_gen && !is_wave && !is_phase;
  assign byte_idx = word_q[9:8];

  // Next state plus the registered strobes, derived from where the FSM goes next
  // so that every output comes straight from a flop.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (rx_done) next_state = EXEC;
      EXEC:     next_state = is_mem ? MEMWR : ACK;
      MEMWR:    next_state = ACK;
      ACK:      next_state = rx_done ? WAIT_REL : IDLE;
      WAIT_REL: if (!rx_done) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    ack_d  = (next_state == ACK);
    we_d   = (next_state == MEMWR);
    err_d  = (next_state == ACK) && (state == EXEC) && is_err;
    busy_d = (next_state != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      uart_ack <= 1'b0;
      mem_we   <= 1'b0;
      cmd_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      uart_ack <= ack_d;
      mem_we   <= we_d;
      cmd_err  <= err_d;
      busy     <= busy_d;
    end
  end

  // Word is captured once in IDLE; later rx_data activity cannot affect the command.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      word_q <= 16'h0000;
    end else if ((state == IDLE) && rx_done) begin
      word_q <= rx_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      gen_en    <= 1'b0;
      wave_type <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state == EXEC) begin
      if (is_mem) begin
        mem_addr  <= ADDR_W'(word_q[14:8]);
        mem_wdata <= DATA_W'(word_q[6:0]);
      end
      if (is_gen) gen_en <= |word_q[11:8];
      if (is_wave) wave_type <= word_q[9:8];
    end
  end

`ifdef PHASE_SHADOW_EN
  // Bytes 0-2 stage into the shadow; byte 3 swaps the full word in at once.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      shadow     <= 24'h000000;
      phase_step <= 32'h00000000;
    end else if ((state == EXEC) && is_phase) begin
      case (byte_idx)
        2'd0:    shadow[7:0]   <= word_q[7:0];
        2'd1:    shadow[15:8]  <= word_q[7:0];
        2'd2:    shadow[23:16] <= word_q[7:0];
        default: phase_step    <= {word_q[7:0], shadow};
      endcase
    end
  end
`else
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      phase_step <= 32'h00000000;
    end else if ((state == EXEC) && is_phase) begin
      case (byte_idx)
        2'd0:    phase_step[7:0]   <= word_q[7:0];
        2'd1:    phase_step[15:8]  <= word_q[7:0];
        2'd2:    phase_step[23:16] <= word_q[7:0];
        default: phase_step[31:24] <= word_q[7:0];
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gen_cmd_ctrl.sv
// Scoreboard bench for gen_cmd_ctrl: expected results are queued per word and checked on ack / write strobes.
`timescale 1ns/1ps

module tb_gen_cmd_ctrl;

  logic        CLOCK_50;
  logic        rst;
  logic [15:0] rx_data;
  logic        rx_done;
  logic        uart_ack;
  logic [31:0] phase_step;
  logic [1:0]  wave_type;
  logic        gen_en;
  logic [6:0]  mem_addr;
  logic [6:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        cmd_err;

  typedef struct packed {
    logic        err;
    logic [31:0] phase;
    logic [1:0]  wave;
    logic        gen;
  } exp_t;

  exp_t        ackq[$];
  logic [13:0] memq[$];

  int checks = 0;
  int errors = 0;
  int ack_count = 0;

  logic [31:0] m_phase;
  logic [23:0] m_shadow;
  logic [1:0]  m_wave;
  logic        m_gen;

  gen_cmd_ctrl #(.ADDR_W(7), .DATA_W(7)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .uart_ack  (uart_ack),
    .phase_step(phase_step),
    .wave_type (wave_type),
    .gen_en    (gen_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT acks a word or strobes a RAM write.
  always @(negedge CLOCK_50) begin
    if (!rst) begin
      if (uart_ack) begin
        ack_count++;
        if (ackq.size() == 0) begin
          checkOutput("ack_unexpected", {31'd0, uart_ack}, 32'd0);
        end else begin
          exp_t e;
          e = ackq.pop_front();
          checkOutput("cmd_err", {31'd0, cmd_err}, {31'd0, e.err});
          checkOutput("phase_step", phase_step, e.phase);
          checkOutput("wave_type", {30'd0, wave_type}, {30'd0, e.wave});
          checkOutput("gen_en", {31'd0, gen_en}, {31'd0, e.gen});
        end
      end else if (cmd_err) begin
        checkOutput("cmd_err_stray", {31'd0, cmd_err}, 32'd0);
      end
      if (mem_we) begin
        if (memq.size() == 0) begin
          checkOutput("we_unexpected", {31'd0, mem_we}, 32'd0);
        end else begin
          logic [13:0] m;
          m = memq.pop_front();
          checkOutput("mem_write", {18'd0, mem_addr, mem_wdata}, {18'd0, m});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] word, input int hold);
    int          n;
    int          we_cycle;
    int          acks_before;
    int          idx;
    logic        is_mem;
    logic [31:0] prev_phase;
    exp_t        e;

    prev_phase = m_phase;
    is_mem     = ~word[15];
    idx        = int'(word[9:8]);
    e.err      = 1'b0;
    if (is_mem) begin
      memq.push_back({word[14:8], word[6:0]});
    end else begin
      case (word[14:12])
        3'b001:  m_gen = |word[11:8];
        3'b010:  m_wave = word[9:8];
        3'b011: begin
`ifdef PHASE_SHADOW_EN
          if (idx == 3) m_phase = {word[7:0], m_shadow};
          else m_shadow[idx*8 +: 8] = word[7:0];
`else
          m_phase[idx*8 +: 8] = word[7:0];
`endif
        end
        default: e.err = 1'b1;
      endcase
    end
    e.phase = m_phase;
    e.wave  = m_wave;
    e.gen   = m_gen;
    ackq.push_back(e);
    acks_before = ack_count;

    @(posedge CLOCK_50); #1;
    rx_data  = word;
    rx_done  = 1'b1;
    n        = 0;
    we_cycle = -1;
    while (n < 20) begin
      @(posedge CLOCK_50); #1;
      n++;
      if (n == 1) begin
        rx_data = ~word;
        checkOutput("phase_early", phase_step, prev_phase);
      end
      if (mem_we) we_cycle = n;
      if (uart_ack) break;
    end
    checkOutput("ack_latency", n, is_mem ? 32'd3 : 32'd2);
    if (is_mem) checkOutput("we_cycle", we_cycle, 32'd2);
    while (n < hold) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    if (is_mem) checkOutput("addr_hold", {25'd0, mem_addr}, {25'd0, word[14:8]});
    rx_done = 1'b0;
    n = 0;
    while (busy && (n < 10)) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    checkOutput("busy_release", {31'd0, busy}, 32'd0);
    checkOutput("ack_count", ack_count - acks_before, 32'd1);
    checkOutput("queues_drained", ackq.size() + memq.size(), 32'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_phase"}, phase_step, 32'd0);
    checkOutput({tag, "_wave"}, {30'd0, wave_type}, 32'd0);
    checkOutput({tag, "_gen"}, {31'd0, gen_en}, 32'd0);
    checkOutput({tag, "_addr"}, {25'd0, mem_addr}, 32'd0);
    checkOutput({tag, "_wdata"}, {25'd0, mem_wdata}, 32'd0);
    checkOutput({tag, "_ctrl"}, {27'd0, mem_we, uart_ack, busy, cmd_err, 1'b0}, 32'd0);
  endtask

  // Reset lands while a RAM write sits in EXEC: no strobe or ack may escape.
  task automatic resetMidCommand();
    int acks_before;
    acks_before = ack_count;
    @(posedge CLOCK_50); #1;
    rx_data = 16'h1122;
    rx_done = 1'b1;
    @(posedge CLOCK_50); #1;
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    m_phase = 32'd0; m_shadow = 24'd0; m_wave = 2'd0; m_gen = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 rx_done = 1'b0;
    @(posedge CLOCK_50); #1;
    checkResetState("mid_reset");
    @(negedge CLOCK_50);
    rst = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkResetState("post_reset");
    checkOutput("reset_no_ack", ack_count - acks_before, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 16'h0000;
    m_phase = 32'd0; m_shadow = 24'd0; m_wave = 2'd0; m_gen = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkResetState("reset");
    @(negedge CLOCK_50);
    rst = 1'b0;

    applyStimulus(16'h2A55, 5);
    applyStimulus(16'h9100, 0);
    applyStimulus(16'hA102, 0);
    applyStimulus(16'hB012, 0);
    applyStimulus(16'hB134, 3);
    applyStimulus(16'hB256, 0);
    applyStimulus(16'hB378, 0);
    applyStimulus(16'hC000, 0);
    applyStimulus(16'hF0FF, 4);
    applyStimulus(16'hB001, 0);
    applyStimulus(16'h9000, 0);
    applyStimulus(16'h7F7F, 0);
    applyStimulus(16'h0000, 6);
    resetMidCommand();
    applyStimulus(16'hA302, 0);
    applyStimulus(16'h1A2B, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
